// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding for pipe_stage_skid instances
// Holds the stage state type; optional perf counters are enabled by PIPE_STAGE_PERF_EN.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high clear
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic inter-stage register with one-entry skid buffer
// Stall/flush counters exist only when PIPE_STAGE_PERF_EN is defined; otherwise they read 0.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  pipe_state_e       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, w_main_nxt;
  logic [DATA_W-1:0] r_skid, w_skid_nxt;
  logic              w_in_fire, w_out_fire;

  // Both handshake outputs depend on state only, so no ready/valid path is combinational.
  assign out_valid_o = (r_state != EMPTY);
  assign in_ready_o  = (r_state != SKID);
  // main is cleared whenever the stage empties, so it already reads 0 while invalid.
  assign out_data_o  = r_main;

  assign w_in_fire  = in_valid_i & in_ready_o;
  assign w_out_fire = out_valid_o & out_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush_i) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = FULL;
            w_main_nxt  = in_data_i;
          end
        end
        FULL: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data_i;
          end else if (w_in_fire) begin
            w_state_nxt = SKID;
            w_skid_nxt  = in_data_i;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = '0;
          end
        end
        SKID: begin
          if (w_out_fire) begin
            w_state_nxt = FULL;
            w_main_nxt  = r_skid;
            w_skid_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (out_valid_o & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_i & (r_state != EMPTY)),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
// Counter expectations follow PIPE_STAGE_PERF_EN.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = 16;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [63:0] EXP_SAT_B = PERF ? 64'd3 : 64'd0;
  localparam logic [63:0] EXP_SAT_A = PERF ? 64'd6 : 64'd0;

  logic          clk = 1'b0;
  logic          rst, flush, iv, ordy;
  logic [DW-1:0] id;
  logic          ov_a, ir_a, ov_b, ir_b;
  logic [DW-1:0] od_a, od_b;
  logic [15:0]   sc_a, fc_a;
  logic [1:0]    sc_b, fc_b;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(iv), .in_ready_o(ir_a), .in_data_i(id),
    .out_valid_o(ov_a), .out_ready_i(ordy), .out_data_o(od_a),
    .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
  );

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(iv), .in_ready_o(ir_b), .in_data_i(id),
    .out_valid_o(ov_b), .out_ready_i(ordy), .out_data_o(od_b),
    .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
  );

  // Reference: the stage is a FIFO of depth 2 with accept-while-not-full.
  logic [DW-1:0] mq[$];
  int            m_stall, m_flush;
  int            n_tests = 0;
  int            n_fail  = 0;

  typedef struct {
    logic          rst, flush, iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          ev;
    logic [DW-1:0] ed;
    logic          er;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    if (!PERF) return 64'd0;
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  task automatic check_model();
    logic          ev, er;
    logic [DW-1:0] ed;
    pipe_state_e   es;
    ev = (mq.size() > 0);
    er = (mq.size() < 2);
    ed = ev ? mq[0] : '0;
    es = (mq.size() == 0) ? EMPTY : (mq.size() == 1) ? FULL : SKID;
    check("a_valid", 64'(ov_a), 64'(ev));
    check("a_ready", 64'(ir_a), 64'(er));
    check("a_data",  64'(od_a), 64'(ed));
    check("a_state", 64'(dut_a.r_state), 64'(es));
    check("b_valid", 64'(ov_b), 64'(ev));
    check("b_data",  64'(od_b), 64'(ed));
    check("a_stall", 64'(sc_a), sat(m_stall, 16));
    check("a_flush", 64'(fc_a), sat(m_flush, 16));
    check("b_stall", 64'(sc_b), sat(m_stall, 2));
    check("b_flush", 64'(fc_b), sat(m_flush, 2));
  endtask

  // Advance the model with the inputs present before the edge, then clock and compare.
  task automatic step();
    bit mv, mr;
    mv = (mq.size() > 0);
    mr = (mq.size() < 2);
    if (rst) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (mv && !ordy) m_stall++;
      if (flush) begin
        if (mv) m_flush++;
        mq.delete();
      end else begin
        if (mv && ordy) void'(mq.pop_front());
        if (iv && mr) mq.push_back(id);
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic [DW-1:0] d, input logic o);
    rst = r; flush = f; iv = v; id = d; ordy = o;
  endtask

  task automatic add(input logic r, input logic f, input logic v, input logic [DW-1:0] d,
                     input logic o, input logic ev, input logic [DW-1:0] ed, input logic er);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = v; t.id = d; t.ordy = o;
    t.ev = ev; t.ed = ed; t.er = er;
    vt.push_back(t);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    //   rst  flush iv   data      ordy  exp_v exp_data  exp_rdy
    add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h0011, 1'b1, 1'b1, 16'h0011, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h0022, 1'b1, 1'b1, 16'h0022, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h0033, 1'b1, 1'b1, 16'h0033, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h00A1, 1'b0, 1'b1, 16'h00A1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h00A2, 1'b0, 1'b1, 16'h00A1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h00A3, 1'b0, 1'b1, 16'h00A1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h00A3, 1'b0, 1'b1, 16'h00A1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'h00A3, 1'b1, 1'b1, 16'h00A2, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h00A3, 1'b1, 1'b1, 16'h00A3, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h00B1, 1'b0, 1'b1, 16'h00B1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h00B2, 1'b0, 1'b1, 16'h00B1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 16'h00B3, 1'b0, 1'b0, 16'h0000, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h00C1, 1'b0, 1'b1, 16'h00C1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 16'h00C2, 1'b0, 1'b0, 16'h0000, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h00C3, 1'b1, 1'b1, 16'h00C3, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h00D1, 1'b0, 1'b1, 16'h00D1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'h00D2, 1'b0, 1'b1, 16'h00D1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 16'h00D3, 1'b0, 1'b0, 16'h0000, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].flush, vt[i].iv, vt[i].id, vt[i].ordy);
      step();
      check($sformatf("vec%0d_valid", i), 64'(ov_a), 64'(vt[i].ev));
      check($sformatf("vec%0d_data", i),  64'(od_a), 64'(vt[i].ed));
      check($sformatf("vec%0d_ready", i), 64'(ir_a), 64'(vt[i].er));
    end

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 2) != 0));
      step();
    end

    // Saturation: one entry held for six stalled cycles.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 16'h00E1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    check("sat_b_stall", 64'(sc_b), EXP_SAT_B);
    check("sat_a_stall", 64'(sc_a), EXP_SAT_A);
    check("sat_hold_data", 64'(od_a), 64'h00E1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
